// File: rtl/mdu_if.sv
// E-stage handshake/bus between the pipeline and the multiply/divide sequencer.
interface mdu_if;
  logic [3:0]  MADOPE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        InsrtMADD;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Start;
  logic        StallMD;

  modport master (
    output MADOPE, SrcAE, SrcBE, InsrtMADD,
    input  HI, LO, Busy, Start, StallMD
  );

  modport slave (
    input  MADOPE, SrcAE, SrcBE, InsrtMADD,
    output HI, LO, Busy, Start, StallMD
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO with fixed-latency busy modelling.
// Divider hardware is present only when MDU_DIV_EN is defined.
module mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [3:0] MULT_CNT0 = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT0  = 4'(DIV_LAT - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, lo_reg;
  logic [31:0] phi_reg, plo_reg;
  logic        dz_reg, dz_next;
  logic [63:0] res_next;
  logic        is_mul, is_div, start, commit;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign prod_s = $signed(bus.SrcAE) * $signed(bus.SrcBE);
  assign prod_u = {32'd0, bus.SrcAE} * {32'd0, bus.SrcBE};

  assign is_mul = (bus.MADOPE == 4'd1) || (bus.MADOPE == 4'd2);
`ifdef MDU_DIV_EN
  logic [31:0]        div_b;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;

  // Substitute a divisor of 1 on divide-by-zero so no X is produced; the result is discarded anyway.
  assign div_b  = (bus.SrcBE == 32'd0) ? 32'd1 : bus.SrcBE;
  assign quo_s  = $signed(bus.SrcAE) / $signed(div_b);
  assign rem_s  = $signed(bus.SrcAE) % $signed(div_b);
  assign quo_u  = bus.SrcAE / div_b;
  assign rem_u  = bus.SrcAE % div_b;
  assign is_div = (bus.MADOPE == 4'd5) || (bus.MADOPE == 4'd6);
`else
  assign is_div = 1'b0;
`endif

  assign start  = (state_reg == IDLE) && (is_mul || is_div);
  assign commit = (state_reg != IDLE) && (cnt_reg == 4'd0);

  always_comb begin
    res_next = {phi_reg, plo_reg};
    dz_next  = 1'b0;
    case (bus.MADOPE)
      4'd1: res_next = prod_s;
      4'd2: res_next = prod_u;
`ifdef MDU_DIV_EN
      4'd5: begin
        res_next = {rem_s, quo_s};
        dz_next  = (bus.SrcBE == 32'd0);
      end
      4'd6: begin
        res_next = {rem_u, quo_u};
        dz_next  = (bus.SrcBE == 32'd0);
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (is_mul) begin
          state_next = MUL;
          cnt_next   = MULT_CNT0;
        end else if (is_div) begin
          state_next = DIV;
          cnt_next   = DIV_CNT0;
        end
      end
      MUL, DIV: begin
        if (cnt_reg == 4'd0) state_next = IDLE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      phi_reg   <= 32'd0;
      plo_reg   <= 32'd0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (start) begin
        phi_reg <= res_next[63:32];
        plo_reg <= res_next[31:0];
        dz_reg  <= dz_next;
      end
      if (commit && !dz_reg) begin
        hi_reg <= phi_reg;
        lo_reg <= plo_reg;
      end
      // Moves are accepted only in IDLE; anything arriving while busy is dropped.
      if (state_reg == IDLE && bus.MADOPE == 4'd3) hi_reg <= bus.SrcAE;
      if (state_reg == IDLE && bus.MADOPE == 4'd4) lo_reg <= bus.SrcAE;
    end
  end

  assign bus.HI      = hi_reg;
  assign bus.LO      = lo_reg;
  assign bus.Busy    = (state_reg != IDLE);
  assign bus.Start   = start;
  assign bus.StallMD = bus.InsrtMADD && (start || (state_reg != IDLE));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed table-driven bench for mdu_ctrl; expectations follow MDU_DIV_EN.
module tb_mdu_ctrl;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        insrt;
    logic        exp_start;
    int          lat;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic insrt, input logic st, input int lat,
                              input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.insrt = insrt; v.exp_start = st;
    v.lat = lat; v.exp_hi = hi; v.exp_lo = lo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic insrt);
    bus.MADOPE    = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    bus.InsrtMADD = insrt;
  endtask

  // Cycle 0 launches; cycles 1..lat are busy with HI/LO held; cycle lat+1 shows the result.
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.op, v.a, v.b, v.insrt);
    #1;
    chk($sformatf("v%0d start", idx), {31'd0, bus.Start}, {31'd0, v.exp_start});
    chk($sformatf("v%0d stall0", idx), {31'd0, bus.StallMD}, {31'd0, v.insrt & v.exp_start});
    for (int c = 1; c <= v.lat; c++) begin
      @(negedge clk);
      drive(4'd0, 32'd0, 32'd0, v.insrt);
      #1;
      chk($sformatf("v%0d busy c%0d", idx, c), {31'd0, bus.Busy}, 32'd1);
      chk($sformatf("v%0d stall c%0d", idx, c), {31'd0, bus.StallMD}, {31'd0, v.insrt});
      chk($sformatf("v%0d hold_hi c%0d", idx, c), bus.HI, model_hi);
      chk($sformatf("v%0d hold_lo c%0d", idx, c), bus.LO, model_lo);
    end
    @(negedge clk);
    drive(4'd0, 32'd0, 32'd0, v.insrt);
    #1;
    chk($sformatf("v%0d busy_end", idx), {31'd0, bus.Busy}, 32'd0);
    chk($sformatf("v%0d stall_end", idx), {31'd0, bus.StallMD}, 32'd0);
    chk($sformatf("v%0d hi", idx), bus.HI, v.exp_hi);
    chk($sformatf("v%0d lo", idx), bus.LO, v.exp_lo);
    model_hi = v.exp_hi;
    model_lo = v.exp_lo;
    $display("vec %0d op=%0d a=%08h b=%08h -> HI=%08h LO=%08h", idx, v.op, v.a, v.b, bus.HI, bus.LO);
  endtask

  initial begin
    vecs[0]  = mk(4'd1, 32'hFFFFFFFD, 32'd5,        1'b1, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    vecs[1]  = mk(4'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 1'b1, 5, 32'h00000001, 32'hFFFFFFFE);
    vecs[2]  = mk(4'd4, 32'h12345678, 32'd0,        1'b1, 1'b0, 0, 32'h00000001, 32'h12345678);
    vecs[3]  = mk(4'd3, 32'hA5A5A5A5, 32'd0,        1'b0, 1'b0, 0, 32'hA5A5A5A5, 32'h12345678);
    vecs[4]  = mk(4'd0, 32'hDEADBEEF, 32'd3,        1'b1, 1'b0, 0, 32'hA5A5A5A5, 32'h12345678);
    vecs[5]  = mk(4'd9, 32'hDEADBEEF, 32'd3,        1'b0, 1'b0, 0, 32'hA5A5A5A5, 32'h12345678);
    vecs[6]  = mk(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, 5, 32'h3FFFFFFF, 32'h00000001);
    vecs[7]  = mk(4'd2, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 5, 32'h40000000, 32'h00000000);
    vecs[8]  = mk(4'd1, 32'h80000000, 32'd1,        1'b0, 1'b1, 5, 32'hFFFFFFFF, 32'h80000000);
`ifdef MDU_DIV_EN
    vecs[9]  = mk(4'd5, 32'hFFFFFFF9, 32'd2,        1'b1, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    vecs[10] = mk(4'd6, 32'd7,        32'd0,        1'b0, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    vecs[11] = mk(4'd6, 32'd100,      32'd7,        1'b0, 1'b1, 10, 32'h00000002, 32'h0000000E);
    vecs[12] = mk(4'd5, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD);
`else
    vecs[9]  = mk(4'd5, 32'hFFFFFFF9, 32'd2,        1'b1, 1'b0, 0, 32'hFFFFFFFF, 32'h80000000);
    vecs[10] = mk(4'd6, 32'd7,        32'd0,        1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'h80000000);
    vecs[11] = mk(4'd6, 32'd100,      32'd7,        1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'h80000000);
    vecs[12] = mk(4'd5, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 0, 32'hFFFFFFFF, 32'h80000000);
`endif

    reset = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst busy", {31'd0, bus.Busy}, 32'd0);
    chk("rst start", {31'd0, bus.Start}, 32'd0);
    chk("rst stall", {31'd0, bus.StallMD}, 32'd0);
    chk("rst hi", bus.HI, 32'd0);
    chk("rst lo", bus.LO, 32'd0);
    $display("reset check HI=%08h LO=%08h Busy=%0b", bus.HI, bus.LO, bus.Busy);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // MTHI during MULT busy is dropped; a new launch is accepted right in cycle LAT+1.
    @(negedge clk);
    drive(4'd1, 32'd6, 32'd7, 1'b0);
    #1;
    chk("seqA start", {31'd0, bus.Start}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) drive(4'd3, 32'hAAAA0000, 32'd0, 1'b0);
      else        drive(4'd0, 32'd0, 32'd0, 1'b0);
      #1;
      chk($sformatf("seqA busy c%0d", c), {31'd0, bus.Busy}, 32'd1);
      chk($sformatf("seqA start c%0d", c), {31'd0, bus.Start}, 32'd0);
      chk($sformatf("seqA hold_hi c%0d", c), bus.HI, model_hi);
    end
    @(negedge clk);
    drive(4'd2, 32'd3, 32'd3, 1'b0);
    #1;
    chk("seqA busy_end", {31'd0, bus.Busy}, 32'd0);
    chk("seqA relaunch", {31'd0, bus.Start}, 32'd1);
    chk("seqA hi", bus.HI, 32'd0);
    chk("seqA lo", bus.LO, 32'd42);
    $display("seqA MULT 6*7 with MTHI in busy -> HI=%08h LO=%08h", bus.HI, bus.LO);
    repeat (5) begin
      @(negedge clk);
      drive(4'd0, 32'd0, 32'd0, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("seqB busy_end", {31'd0, bus.Busy}, 32'd0);
    chk("seqB hi", bus.HI, 32'd0);
    chk("seqB lo", bus.LO, 32'd9);
    $display("seqB MULTU 3*3 back-to-back -> HI=%08h LO=%08h", bus.HI, bus.LO);

    // Reset in cycle 3 of an in-flight op aborts it without a late commit.
    @(negedge clk);
    drive(4'd3, 32'h11111111, 32'd0, 1'b0);
    @(negedge clk);
`ifdef MDU_DIV_EN
    drive(4'd5, 32'hFFFFFFF9, 32'd2, 1'b0);
`else
    drive(4'd1, 32'd5, 32'd5, 1'b0);
`endif
    #1;
    chk("seqC start", {31'd0, bus.Start}, 32'd1);
    chk("seqC hi_pre", bus.HI, 32'h11111111);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      if (c == 3) reset = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("seqC busy", {31'd0, bus.Busy}, 32'd0);
    chk("seqC hi", bus.HI, 32'd0);
    chk("seqC lo", bus.LO, 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("seqC late_busy c%0d", c), {31'd0, bus.Busy}, 32'd0);
      chk($sformatf("seqC late_hi c%0d", c), bus.HI, 32'd0);
      chk($sformatf("seqC late_lo c%0d", c), bus.LO, 32'd0);
    end
    $display("seqC reset mid-op -> HI=%08h LO=%08h Busy=%0b", bus.HI, bus.LO, bus.Busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit with its own sequencer, owning the HI/LO registers for the pipelined MIPS core. It sits in the E stage. It accepts the decoded MADOP and operands, models fixed multi-cycle latencies with a busy counter, and commits results to HI/LO on completion. It also produces the combinational stall request that freezes D while an HI/LO-dependent instruction would otherwise issue into a busy unit.

## Interface
Parameters:
- `MULT_LAT`, 5: busy cycles for MULT/MULTU (legal range 1–15)
- `DIV_LAT`, 10: busy cycles for DIV/DIVU (legal range 1–15)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low; 0 at a rising edge clears all state
- `MADOPE`  in  4  E-stage op: 0 none, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 DIV, 6 DIVU, 7–15 none
- `SrcAE`  in  32  rs operand, forwarded
- `SrcBE`  in  32  rt operand, forwarded
- `InsrtMADD`  in  1  D-stage instruction uses the MDU (any of MFHI, MFLO, MULT, MULTU, MTHI, MTLO, DIV, DIVU)
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `Busy`  out  1  operation in flight
- `Start`  out  1  combinational; E-stage op launches this cycle
- `StallMD`  out  1  combinational; stall request to the hazard unit

## Operation
- FSM states: IDLE, MUL, DIV. Counter `cnt` is 4 bits.
- Start = (state == IDLE) & MADOPE ∈ {1,2,5,6}.
- Launch in IDLE:
  - MULT/MULTU: go to MUL, cnt ← MULT_LAT−1.
  - DIV/DIVU: go to DIV, cnt ← DIV_LAT−1.
  - Full result computed and latched into pending registers `phi`/`plo` at the launch edge.
- MULT: signed 32×32 → 64; phi = [63:32], plo = [31:0]. MULTU: same, unsigned.
- DIV: signed; plo = quotient truncated toward zero, phi = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (SrcBE == 0): FSM sequences normally, but HI/LO are left unchanged on commit.
- MUL/DIV states: cnt decrements each cycle. At cnt == 0: HI ← phi, LO ← plo, go to IDLE.
- MTHI/MTLO in IDLE: HI or LO ← SrcAE at that edge. No busy.
- Any MADOPE while not IDLE is ignored. The pipeline guarantees this does not occur; the block must still not corrupt state.
- Busy = (state != IDLE).
- StallMD = InsrtMADD & (Start | Busy).
- Reset: state = IDLE, cnt = 0, HI = LO = phi = plo = 0. Busy = 0. Reset aborts an in-flight operation with no commit.

## Timing
- Launch edge ends cycle 0, the cycle in which Start = 1.
- Busy = 1 during cycles 1..LAT.
- HI/LO take the new value at the edge ending cycle LAT, so it is first visible in cycle LAT+1 with Busy = 0.
- Back-to-back ops: a new launch is possible in cycle LAT+1.
- MTHI/MTLO: the value is visible in cycle 1.
- StallMD asserts in cycle 0 through cycle LAT whenever InsrtMADD = 1.
- StallMD, Start and Busy are glitch-free functions of registered state plus MADOPE/InsrtMADD. No other combinational path exists.
- An E-stage flush during Busy has no effect. Once launched, an op always completes.

## Configuration
- `MDU_DIV_EN`:
  - Defined: DIV/DIVU are supported as above.
  - Undefined: no divider hardware. MADOPE 5/6 are treated as op 0 (Start = 0, no state change, HI/LO untouched), and the DIV state is unreachable.

## Test plan
- MULT, SrcAE = 0xFFFFFFFD (−3), SrcBE = 5 → Busy high cycles 1–5; in cycle 6 HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULTU, 0xFFFFFFFF × 2 → after 5 busy cycles HI = 0x00000001, LO = 0xFFFFFFFE. HI/LO hold their prior values during busy.
- DIV, −7 / 2 → Busy cycles 1–10; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU, 7 / 0 → 10 busy cycles, HI/LO unchanged. Without `MDU_DIV_EN`: no busy, HI/LO unchanged.
- MTLO 0x12345678 in IDLE → LO = 0x12345678 next cycle. MTHI 0xAAAA0000 issued during MULT busy → ignored; HI equals the MULT result after completion.
- InsrtMADD = 1 (MFLO) while MULT launches → StallMD = 1 for cycles 0–5, 0 in cycle 6.
- reset = 0 in cycle 3 of a DIV → next cycle Busy = 0, HI = LO = 0, with no late commit thereafter.
